// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - byte-stream loader that packs little-endian operand bytes into a word bank
// Words commit one cycle after their last byte; the bank itself is never reset.
module operand_loader #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 64,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             in_ready,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic [CW-1:0]    word_count,
   output logic             loaded,
   output logic             overflow
);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_COMMIT, S_DONE} state_t;

   localparam logic [CW-1:0] LAST_SLOT = CW'(DEPTH - 1);

   state_t           state;
   logic             ready_q;
   logic [2:0]       byte_idx;
   logic             last_q;
   logic [WIDTH-1:0] assembly;
   logic [WIDTH-1:0] bank [DEPTH];
   logic             accept;

   // clear blocks acceptance combinationally so a byte offered alongside it is dropped
   assign in_ready = ready_q & ~clear;
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         ready_q    <= 1'b0;
         byte_idx   <= 3'd0;
         last_q     <= 1'b0;
         assembly   <= '0;
         word_count <= '0;
         loaded     <= 1'b0;
         overflow   <= 1'b0;
      end else if (clear) begin
         state      <= S_IDLE;
         ready_q    <= 1'b1;
         byte_idx   <= 3'd0;
         last_q     <= 1'b0;
         assembly   <= '0;
         word_count <= '0;
         loaded     <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               ready_q <= 1'b1;
               if (accept) begin
                  assembly <= {{(WIDTH-8){1'b0}}, in_data};
                  byte_idx <= 3'd1;
                  last_q   <= in_last;
                  if (in_last) begin
                     state   <= S_COMMIT;
                     ready_q <= 1'b0;
                  end else begin
                     state   <= S_FILL;
                  end
               end
            end
            S_FILL: begin
               if (accept) begin
                  assembly[{byte_idx, 3'b000} +: 8] <= in_data;
                  byte_idx <= byte_idx + 3'd1;
                  if (byte_idx == 3'd7 || in_last) begin
                     state   <= S_COMMIT;
                     ready_q <= 1'b0;
                     last_q  <= in_last;
                  end
               end
            end
            S_COMMIT: begin
               assembly <= '0;
               byte_idx <= 3'd0;
               last_q   <= 1'b0;
               if (word_count <= LAST_SLOT)
                  word_count <= word_count + 1'b1;
               if (last_q || word_count == LAST_SLOT) begin
                  state  <= S_DONE;
                  loaded <= 1'b1;
               end else begin
                  state   <= S_IDLE;
                  ready_q <= 1'b1;
               end
            end
            S_DONE: begin
               ready_q <= 1'b0;
               if (in_valid)
                  overflow <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // the pending word still lands in the bank when clear coincides with COMMIT
   always_ff @(posedge clock) begin
      if (state == S_COMMIT)
         bank[word_count[AW-1:0]] <= assembly;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         rd_data <= '0;
      else
         rd_data <= bank[rd_addr];
   end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter DEPTH, default 32, number of 64-bit operand words in the bank.
REQ-002 Parameter WIDTH, default 64, bank word width in bits; fixed at 8 bytes per word.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low; clock clock.
REQ-005 clear  input  1  synchronous restart of loading; bank contents retained.
REQ-006 in_valid  input  1  in_data/in_last carry a byte this cycle.
REQ-007 in_data  input  8  operand byte stream, little-endian within each word.
REQ-008 in_last  input  1  qualifies the final byte of the load frame.
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 rd_addr  input  5  bank read address from the multiplier controller.
REQ-011 rd_data  output  64  registered bank word at rd_addr.
REQ-012 word_count  output  6  number of words committed since reset/clear (0..32).
REQ-013 loaded  output  1  frame complete; bank is valid for reading.
REQ-014 overflow  output  1  sticky; byte offered (in_valid) while in DONE.

Function
REQ-015 A byte is transferred only on a rising edge with in_valid=1 and in_ready=1.
REQ-016 FSM states: IDLE, FILL, COMMIT, DONE.
REQ-017 IDLE: in_ready=1; first accepted byte goes to FILL with byte_idx=1.
REQ-018 FILL: in_ready=1; each accepted byte stored at bits [8*byte_idx+7 : 8*byte_idx] of the assembly register; byte_idx increments.
REQ-019 FILL -> COMMIT when byte with byte_idx=7 is accepted or when an accepted byte has in_last=1.
REQ-020 The first byte of a word occupies bits [7:0]; unfilled upper bytes of a word ended by in_last are written as zero.
REQ-021 COMMIT: in_ready=0 for exactly one cycle; assembly register written to bank[word_count]; word_count increments; assembly register and byte_idx cleared.
REQ-022 COMMIT -> DONE if the committed word ended with in_last or word_count reaches DEPTH; otherwise -> IDLE.
REQ-023 DONE: in_ready=0, loaded=1; remains until clear or reset.
REQ-024 Any in_valid=1 cycle in DONE sets overflow; overflow cleared only by clear or reset.
REQ-025 clear=1 forces IDLE next cycle, word_count=0, byte_idx=0, loaded=0, overflow=0, assembly register zeroed; clear has priority over any byte transfer in the same cycle (byte not accepted, in_ready driven 0 while clear=1).
REQ-026 clear during COMMIT: the pending word is still written to the bank, but word_count is forced to 0.
REQ-027 in_last on the 8th byte of word 31 produces a single commit and DONE; no extra empty word.
REQ-028 Throughput: one word per 9 cycles at full rate (8 byte cycles + 1 COMMIT cycle).
REQ-029 rd_data updates one cycle after rd_addr (registered read); reading the address being written in COMMIT returns the old contents that cycle and the new contents thereafter.
REQ-030 rd_data is readable in every state; no read handshake.
REQ-031 word_count saturates at DEPTH; no wrap-around to 0 except through clear/reset.

Reset
REQ-032 While reset=0: state=IDLE, in_ready=0, word_count=0, loaded=0, overflow=0, byte_idx=0, assembly register=0, rd_data=0.
REQ-033 First rising edge after reset release: in_ready=1; bank contents are not reset and are undefined until written.

Verification
REQ-034 Bytes 0x01..0x08 streamed back-to-back, in_last on 0x08 -> COMMIT on 9th cycle, bank[0]=0x0807060504030201, word_count=1, loaded=1.
REQ-035 Bytes 0xAA,0xBB with in_last on 0xBB -> bank[0]=0x000000000000BBAA, loaded=1, in_ready=0.
REQ-036 256 bytes without in_last -> word_count=32, loaded=1; further in_valid sets overflow=1, no bank write.
REQ-037 in_valid toggled randomly (50%) across 3 words -> identical bank contents as back-to-back run; no byte lost or duplicated.
REQ-038 clear asserted in the same cycle as the 5th byte of word 2 -> byte rejected, word_count=0, IDLE next cycle, bank[0..1] unchanged.
REQ-039 reset asserted mid-FILL (byte_idx=3) -> all outputs to REQ-032 values immediately; reload after release writes from bank[0].
